// File: rtl/reset_request_gen.sv
`default_nettype none
// ============================================================================
// Module   : reset_request_gen
// Purpose  : Converts a raw, bouncy reset push-button (and, optionally, a host
//            software reset strobe) into one clean, fixed-width, active-low
//            reset request for the downstream reset sequencer. A hold-off
//            window blocks retriggering while the button is held or bouncing.
// Ports    : i_clk         system clock, rising edge
//            _rst          asynchronous active-low reset of this block
//            i_button      raw asynchronous push-button pin
//            i_sw_rst_req  1-cycle software reset strobe (RESET_REQ_SW_EN only)
//            _o_rst        active-low reset request (registered)
//            o_rst         active-high copy of the request (registered)
//            o_busy        high while in ASSERT or HOLDOFF (registered)
//            o_cause       {button, sw} of the last request, sticky
// Config   : define RESET_REQ_SW_EN to add the software request path;
//            without it i_sw_rst_req is absent and o_cause[0] is always 0.
// Revision : 1.0 - initial release
// ============================================================================
module reset_request_gen #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int PULSE_CYCLES      = 8,
  parameter int HOLDOFF_CYCLES    = 32,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       _rst,
  input  logic       i_button,
`ifdef RESET_REQ_SW_EN
  input  logic       i_sw_rst_req,
`endif
  output logic       _o_rst,
  output logic       o_rst,
  output logic       o_busy,
  output logic [1:0] o_cause
);

  localparam int MAX_CNT = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  // Pin level that means "released"; the sync chain resets to this value.
  localparam logic RELEASED_PIN = BUTTON_ACTIVE_LOW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer, polarity normalized to pressed = 1 after the chain
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_btn;

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      r_sync1 <= RELEASED_PIN;
      r_sync2 <= RELEASED_PIN;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn = BUTTON_ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // --------------------------------------------------------------------------
  // Debounce: the level must differ for DEBOUNCE_CYCLES consecutive cycles;
  // any matching cycle restarts the count so short glitches never flip it.
  // --------------------------------------------------------------------------
  logic            r_db;
  logic            r_db_q;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_press;
  logic            w_sw;

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      r_db     <= 1'b0;
      r_db_q   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_db_q <= r_db;
      if (w_btn == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db     <= w_btn;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Press event is the cycle right after the debounced level rises.
  assign w_press = r_db & ~r_db_q;

`ifdef RESET_REQ_SW_EN
  assign w_sw = i_sw_rst_req;
`else
  assign w_sw = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Request FSM
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_nxt;
  logic             r_rst_n;
  logic             r_rst;
  logic             r_busy;

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cause <= 2'b00;
      r_rst_n <= 1'b1;
      r_rst   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= w_cause_nxt;
      // Outputs decoded from the next state so they are plain flops.
      r_rst_n <= (w_state_nxt != S_ASSERT);
      r_rst   <= (w_state_nxt == S_ASSERT);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    case (r_state)
      S_IDLE: begin
        if (w_press || w_sw) begin
          w_state_nxt = S_ASSERT;
          w_cnt_nxt   = '0;
          w_cause_nxt = {w_press, w_sw};
        end
      end
      S_ASSERT: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_nxt = S_HOLDOFF;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HOLDOFF: begin
        // Counter saturates at done; a held button keeps us here.
        if (r_cnt == HOLD_LAST) begin
          if (!r_db) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign _o_rst  = r_rst_n;
  assign o_rst   = r_rst;
  assign o_busy  = r_busy;
  assign o_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_reset_request_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_request_gen
// Purpose  : Self-checking bench for reset_request_gen. Every expected reset
//            pulse (start cycle, width, cause) is queued by the stimulus; a
//            monitor measures each pulse on _o_rst and compares it.
//            A second instance with 1-cycle parameters covers the minimum
//            configuration. Software-path scenarios need RESET_REQ_SW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_request_gen;

  typedef struct {
    int         start;
    int         len;
    logic [1:0] cause;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       btn_pressed;
  logic       sw_req;
  logic       req_n;
  logic       req;
  logic       busy;
  logic [1:0] cause;

  logic       btn_f;
  logic       req_n_f;
  logic       req_f;
  logic       busy_f;
  logic [1:0] cause_f;

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  reset_request_gen u_dut (
    .i_clk        (clk),
    ._rst         (rst_n),
    .i_button     (~btn_pressed),
`ifdef RESET_REQ_SW_EN
    .i_sw_rst_req (sw_req),
`endif
    ._o_rst       (req_n),
    .o_rst        (req),
    .o_busy       (busy),
    .o_cause      (cause)
  );

  reset_request_gen #(
    .DEBOUNCE_CYCLES   (1),
    .PULSE_CYCLES      (1),
    .HOLDOFF_CYCLES    (1),
    .BUTTON_ACTIVE_LOW (1'b0)
  ) u_dut_fast (
    .i_clk        (clk),
    ._rst         (rst_n),
    .i_button     (btn_f),
`ifdef RESET_REQ_SW_EN
    .i_sw_rst_req (1'b0),
`endif
    ._o_rst       (req_n_f),
    .o_rst        (req_f),
    .o_busy       (busy_f),
    .o_cause      (cause_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Pulse monitor on the default instance
  // --------------------------------------------------------------------------
  logic       mon_in_pulse = 1'b0;
  int         mon_start;
  int         mon_len;
  logic [1:0] mon_cause;
  exp_t       mon_exp;

  always @(negedge clk) begin
    if (!req_n) begin
      if (!mon_in_pulse) begin
        mon_in_pulse = 1'b1;
        mon_start    = cyc;
        mon_len      = 0;
        mon_cause    = cause;
      end
      mon_len++;
    end else if (mon_in_pulse) begin
      mon_in_pulse = 1'b0;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got start=%0d len=%0d cause=%b, no pulse expected",
                 mon_start, mon_len, mon_cause);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_exp.start != mon_start || mon_exp.len != mon_len || mon_exp.cause != mon_cause) begin
          n_fail++;
          $display("FAIL pulse: got start=%0d len=%0d cause=%b, expected start=%0d len=%0d cause=%b",
                   mon_start, mon_len, mon_cause, mon_exp.start, mon_exp.len, mon_exp.cause);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int start, input int len, input logic [1:0] c);
    exp_t e;
    e.start = start;
    e.len   = len;
    e.cause = c;
    sb_q.push_back(e);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int k;
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    btn_pressed = 1'b0;
    sw_req      = 1'b0;
    btn_f       = 1'b0;

    // Reset state, then idle with the button released
    tick(3);
    check("reset_outputs", {28'd0, req_n, req, busy, cause}, 32'b1_0_0_00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(20);
      check("idle_outputs", {28'd0, req_n, req, busy, cause}, 32'b1_0_0_00);
    end

    // Clean press held 100 cycles
    k = cyc;
    btn_pressed = 1'b1;
    expect_pulse(k + 19, 8, 2'b10);
    tick(19);
    check("busy_at_pulse_start", {31'd0, busy}, 32'd1);
    check("o_rst_at_pulse_start", {31'd0, req}, 32'd1);
    tick(81);
    btn_pressed = 1'b0;
    tick(18);
    check("busy_until_db_release", {31'd0, busy}, 32'd1);
    check("cause_sticky", {30'd0, cause}, 32'b10);
    tick(1);
    check("busy_clear_after_holdoff", {31'd0, busy}, 32'd0);
    tick(20);

    // Bouncing press: 5-cycle pulses for 60 cycles, then released
    for (int i = 0; i < 6; i++) begin
      btn_pressed = 1'b1;
      tick(5);
      btn_pressed = 1'b0;
      tick(5);
    end
    tick(40);
    check("bounce_no_request", {29'd0, req_n, busy, 1'b0}, 32'b100);

`ifdef RESET_REQ_SW_EN
    // Software strobe, ignored second strobe, coincident strobe + press
    k = cyc;
    sw_req = 1'b1;
    expect_pulse(k + 1, 8, 2'b01);
    tick(1);
    sw_req = 1'b0;
    tick(14);
    check("busy_in_holdoff", {31'd0, busy}, 32'd1);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    tick(45);
    check("idle_after_sw", {31'd0, busy}, 32'd0);

    k = cyc;
    btn_pressed = 1'b1;
    tick(18);
    sw_req = 1'b1;
    expect_pulse(k + 19, 8, 2'b11);
    tick(1);
    sw_req = 1'b0;
    tick(21);
    btn_pressed = 1'b0;
    tick(70);
    check("idle_after_coincident", {31'd0, busy}, 32'd0);
`endif

    // Reset during the third low cycle; button stays held through reset
    k = cyc;
    btn_pressed = 1'b1;
    expect_pulse(k + 19, 2, 2'b10);
    tick(21);
    rst_n = 1'b0;
    #1;
    check("async_reset_rst_n", {31'd0, req_n}, 32'd1);
    check("async_reset_o_rst", {31'd0, req}, 32'd0);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_cause", {30'd0, cause}, 32'd0);
    tick(3);
    k = cyc;
    rst_n = 1'b1;
    expect_pulse(k + 19, 8, 2'b10);
    tick(60);
    btn_pressed = 1'b0;
    tick(80);
    check("idle_after_reset_case", {31'd0, busy}, 32'd0);

    // Minimum-parameter instance (active-high button)
    k = cyc;
    btn_f = 1'b1;
    tick(3);
    check("fast_before_pulse", {31'd0, req_n_f}, 32'd1);
    tick(1);
    check("fast_pulse_low", {30'd0, req_n_f, req_f}, 32'b01);
    check("fast_cause", {30'd0, cause_f}, 32'b10);
    tick(1);
    check("fast_pulse_one_cycle", {30'd0, req_n_f, busy_f}, 32'b11);
    tick(5);
    btn_f = 1'b0;
    tick(3);
    check("fast_busy_held", {31'd0, busy_f}, 32'd1);
    tick(1);
    check("fast_rearmed", {31'd0, busy_f}, 32'd0);
    tick(6);
    btn_f = 1'b1;
    tick(4);
    check("fast_second_pulse_low", {31'd0, req_n_f}, 32'd0);
    tick(1);
    check("fast_second_pulse_end", {31'd0, req_n_f}, 32'd1);
    btn_f = 1'b0;
    tick(10);

    check("all_expected_pulses_seen", sb_q.size(), 32'd0);
    check("no_pulse_open", {31'd0, mon_in_pulse}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
